tiny_riscv_mem_arbiter: RTL and testbench
=========================================

Name: tiny_riscv_mem_arbiter

Overview:
- Shares one single-port synchronous word RAM between two requesters of tiny_riscv_processor: the instruction-fetch port (I, read-only) and the load/store data port (D, read/write).
- Arbitrates one access per cycle, issues it to the RAM on the next cycle with registered signals, and returns the response to the owning port at a fixed latency.
- Sits between the processor core and the RAM, in the w_internal_Clock domain.

Parameters:
- ADDR_W, 10, word-address width of the RAM.
- ARB_MODE, 0. Selects arbitration: 0 = round-robin; 1 = D-priority with starvation guard.
- MAX_WAIT, 4. In ARB_MODE 1, the number of consecutive cycles I may be denied while valid before it is forced to win. Legal range 1..15.

Ports:
- i_Clk  in  1  clock; all logic on the rising edge.
- i_Rst  in  1  reset: synchronous, active-high.
- i_I_Valid  in  1  I requests a read.
- i_I_Addr  in  ADDR_W  I word address.
- o_I_Ready  out  1  I request accepted this cycle.
- o_I_Rsp_Valid  out  1  I read data valid.
- o_I_Rsp_Data  out  32  I read data.
- i_D_Valid  in  1  D requests an access.
- i_D_Wr  in  1  1 = write, 0 = read.
- i_D_Addr  in  ADDR_W  D word address.
- i_D_WData  in  32  D write data.
- i_D_WStrb  in  4  D byte enables; bit n controls byte n.
- o_D_Ready  out  1  D request accepted this cycle.
- o_D_Rsp_Valid  out  1  D response valid (read data, or write acknowledge).
- o_D_Rsp_Data  out  32  D read data; 0 for a write acknowledge.
- o_Mem_En  out  1  RAM access strobe.
- o_Mem_We  out  4  RAM byte write enables.
- o_Mem_Addr  out  ADDR_W  RAM word address.
- o_Mem_WData  out  32  RAM write data.
- i_Mem_RData  in  32  RAM read data, valid 1 cycle after o_Mem_En.

Behaviour:
- Handshake: a request transfers in cycle N when Valid & Ready.
  - Ready is combinational from the Valid inputs and the arbiter state.
  - Ready is asserted only to the winner, and only while its Valid is high; never to both ports in one cycle.
  - Requesters hold Addr/WData/WStrb/Wr stable while Valid is high and Ready is low.
- Pipeline, for a transfer in cycle N:
  - Cycle N+1: o_Mem_En=1, with o_Mem_Addr, o_Mem_WData and o_Mem_We registered from the request (o_Mem_We = WStrb for a write, 4'b0000 for a read).
  - Cycle N+2: the owner's Rsp_Valid=1 for exactly one cycle.
    - Read: Rsp_Data = i_Mem_RData.
    - Write (D only): Rsp_Data = 0.
  - The non-owner's Rsp_Valid stays 0.
- Throughput: one transfer per cycle. Back-to-back transfers from either port are legal; responses return in acceptance order.
- Round-robin (ARB_MODE 0):
  - Only one port valid: that port wins.
  - Both valid: the port not granted most recently wins.
  - The last-grant pointer updates only on a transfer.
- D-priority (ARB_MODE 1):
  - Both valid: D wins, unless the I wait counter == MAX_WAIT, in which case I wins.
  - I wait counter: increments each cycle i_I_Valid=1 and I is not granted; clears on an I transfer or when i_I_Valid=0; saturates at MAX_WAIT.
- Idle cycle (no transfer): the next cycle has o_Mem_En=0 and o_Mem_We=0. o_Mem_Addr and o_Mem_WData hold their previous values.
- Reset (i_Rst=1 at a clock edge):
  - All outputs become 0 on that edge: Ready, Rsp_Valid, Rsp_Data, Mem_En, Mem_We, Mem_Addr, Mem_WData.
  - Last-grant pointer = I, so D wins the first tie in round-robin.
  - Wait counter = 0.
  - In-flight accesses are dropped: no Rsp_Valid in the two cycles after reset, even if a transfer occurred in the cycle before reset.
  - Ready stays 0 while i_Rst=1.
- Address and data pass unmodified; no width conversion; addresses are word indices.

Test Plan:
- Single I read: RAM[5]=0xDEADBEEF; I_Valid, I_Addr=5 for 1 cycle -> I_Ready same cycle; Mem_En, Mem_Addr=5, Mem_We=0 next cycle; I_Rsp_Valid=1 with I_Rsp_Data=0xDEADBEEF two cycles after acceptance; D_Rsp_Valid=0 throughout.
- D byte write then read: write Addr=3, WData=0x11223344, WStrb=4'b0101 over RAM[3]=0 -> Mem_We=4'b0101, D_Rsp_Valid with data 0; then read Addr=3 -> D_Rsp_Data=0x00220044.
- Round-robin contention (ARB_MODE 0): both ports held valid for 6 cycles right after reset -> grants D,I,D,I,D,I; one transfer per cycle; responses alternate D,I,… at +2 cycles.
- Starvation guard (ARB_MODE 1, MAX_WAIT=4): both ports held valid -> grants D,D,D,D,I,D,D,D,D,I; the wait counter clears after each I grant.
- Reset mid-flight: accept a D read in cycle N, assert i_Rst in cycle N+1 -> no D_Rsp_Valid in N+2; all outputs 0 after the edge; first tie after reset is granted to D.
- Stalled requester: I valid with Addr=7 while D wins for 3 cycles (ARB_MODE 1) -> I_Ready=0 in those cycles; after I is accepted, Mem_Addr=7 and the correct data returns.

Source files
------------

// File: rtl/tiny_riscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tiny_riscv_mem_arbiter
//
// Shares one single-port synchronous word RAM between the instruction-fetch
// port (I, read-only) and the load/store data port (D, read/write) of
// tiny_riscv_processor. One request is accepted per cycle, issued to the RAM
// on the next cycle from registers, and answered to its owner two cycles after
// acceptance.
//
// Handshake: a request transfers in the cycle where Valid & Ready are both
// high. Ready is combinational from the Valid inputs and the arbiter state, is
// given only to the winning port while its Valid is high, never to both ports
// at once, and is held low during reset. A requester keeps Addr/WData/WStrb/Wr
// stable while Valid is high and Ready is low.
//
// Parameters:
//   ADDR_W   - RAM word-address width
//   ARB_MODE - 0: round-robin, 1: D-priority with starvation guard for I
//   MAX_WAIT - (mode 1) consecutive denied cycles before I is forced to win
//
// Ports:
//   i_Clk, i_Rst                 - clock, synchronous active-high reset
//   i_I_Valid/i_I_Addr/o_I_Ready - I request channel
//   o_I_Rsp_Valid/o_I_Rsp_Data   - I read response
//   i_D_Valid/i_D_Wr/i_D_Addr/i_D_WData/i_D_WStrb/o_D_Ready - D request
//   o_D_Rsp_Valid/o_D_Rsp_Data   - D response (read data, 0 for writes)
//   o_Mem_En/o_Mem_We/o_Mem_Addr/o_Mem_WData - registered RAM command
//   i_Mem_RData                  - RAM read data, one cycle after o_Mem_En
// -----------------------------------------------------------------------------
module tiny_riscv_mem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int ARB_MODE = 0,
    parameter int MAX_WAIT = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_I_Valid,
    input  logic [ADDR_W-1:0] i_I_Addr,
    output logic              o_I_Ready,
    output logic              o_I_Rsp_Valid,
    output logic [31:0]       o_I_Rsp_Data,
    input  logic              i_D_Valid,
    input  logic              i_D_Wr,
    input  logic [ADDR_W-1:0] i_D_Addr,
    input  logic [31:0]       i_D_WData,
    input  logic [3:0]        i_D_WStrb,
    output logic              o_D_Ready,
    output logic              o_D_Rsp_Valid,
    output logic [31:0]       o_D_Rsp_Data,
    output logic              o_Mem_En,
    output logic [3:0]        o_Mem_We,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [31:0]       o_Mem_WData,
    input  logic [31:0]       i_Mem_RData
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    // Arbiter state
    logic              last_d_q, last_d_d;       // 1 = D was granted most recently
    logic [3:0]        wait_cnt_q, wait_cnt_d;   // consecutive denied cycles of I

    // Issue stage (cycle N+1)
    logic              mem_en_q, mem_en_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              s1_is_d_q, s1_is_d_d;
    logic              s1_wr_q, s1_wr_d;

    // Response stage (cycle N+2)
    logic              rsp_i_q, rsp_i_d;
    logic              rsp_d_q, rsp_d_d;
    logic              rsp_wr_q, rsp_wr_d;

    logic              grant_i, grant_d;

    // Winner selection; a lone valid port always wins.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!i_Rst) begin
            if (i_I_Valid && i_D_Valid) begin
                if (ARB_MODE == 0) begin
                    if (last_d_q) grant_i = 1'b1;
                    else          grant_d = 1'b1;
                end else begin
                    if (wait_cnt_q == MAX_WAIT_C) grant_i = 1'b1;
                    else                          grant_d = 1'b1;
                end
            end else begin
                grant_i = i_I_Valid;
                grant_d = i_D_Valid;
            end
        end
    end

    always_comb begin
        last_d_d    = last_d_q;
        wait_cnt_d  = 4'd0;
        mem_en_d    = grant_i | grant_d;
        mem_we_d    = 4'b0000;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        s1_is_d_d   = grant_d;
        s1_wr_d     = grant_d & i_D_Wr;
        rsp_i_d     = mem_en_q & ~s1_is_d_q;
        rsp_d_d     = mem_en_q & s1_is_d_q;
        rsp_wr_d    = s1_wr_q;

        if (grant_d) begin
            last_d_d    = 1'b1;
            mem_addr_d  = i_D_Addr;
            mem_wdata_d = i_D_WData;
            if (i_D_Wr) mem_we_d = i_D_WStrb;
        end else if (grant_i) begin
            last_d_d   = 1'b0;
            mem_addr_d = i_I_Addr;
        end

        // Counts only while I is valid and losing; saturates at MAX_WAIT.
        if (i_I_Valid && !grant_i) begin
            if (wait_cnt_q == MAX_WAIT_C) wait_cnt_d = wait_cnt_q;
            else                          wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // Reset also drops both pipeline stages, so in-flight accesses never respond.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            last_d_q    <= 1'b0;
            wait_cnt_q  <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            s1_is_d_q   <= 1'b0;
            s1_wr_q     <= 1'b0;
            rsp_i_q     <= 1'b0;
            rsp_d_q     <= 1'b0;
            rsp_wr_q    <= 1'b0;
        end else begin
            last_d_q    <= last_d_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            s1_is_d_q   <= s1_is_d_d;
            s1_wr_q     <= s1_wr_d;
            rsp_i_q     <= rsp_i_d;
            rsp_d_q     <= rsp_d_d;
            rsp_wr_q    <= rsp_wr_d;
        end
    end

    assign o_I_Ready     = grant_i;
    assign o_D_Ready     = grant_d;
    assign o_Mem_En      = mem_en_q;
    assign o_Mem_We      = mem_we_q;
    assign o_Mem_Addr    = mem_addr_q;
    assign o_Mem_WData   = mem_wdata_q;
    assign o_I_Rsp_Valid = rsp_i_q;
    assign o_D_Rsp_Valid = rsp_d_q;
    // RAM data arrives in the response cycle, so it is steered straight through.
    assign o_I_Rsp_Data  = rsp_i_q ? i_Mem_RData : 32'd0;
    assign o_D_Rsp_Data  = (rsp_d_q && !rsp_wr_q) ? i_Mem_RData : 32'd0;

endmodule

// File: tb/tb_tiny_riscv_mem_arbiter.sv
module tb_tiny_riscv_mem_arbiter;
  localparam int AW = 10;
  localparam int MW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          iv[2];
  logic [AW-1:0] ia[2];
  logic          ir[2];
  logic          irv[2];
  logic [31:0]   ird[2];
  logic          dv[2];
  logic          dwr[2];
  logic [AW-1:0] da[2];
  logic [31:0]   dwd[2];
  logic [3:0]    ds[2];
  logic          dr[2];
  logic          drv[2];
  logic [31:0]   drd[2];
  logic          men[2];
  logic [3:0]    mwe[2];
  logic [AW-1:0] maddr[2];
  logic [31:0]   mwd[2];
  logic [31:0]   mrd[2];

  // Instance 0: round-robin, instance 1: D-priority with MAX_WAIT=4
  for (genvar k = 0; k < 2; k++) begin : g_dut
    tiny_riscv_mem_arbiter #(.ADDR_W(AW), .ARB_MODE(k), .MAX_WAIT(MW)) u_dut (
      .i_Clk(clk), .i_Rst(rst),
      .i_I_Valid(iv[k]), .i_I_Addr(ia[k]), .o_I_Ready(ir[k]),
      .o_I_Rsp_Valid(irv[k]), .o_I_Rsp_Data(ird[k]),
      .i_D_Valid(dv[k]), .i_D_Wr(dwr[k]), .i_D_Addr(da[k]), .i_D_WData(dwd[k]),
      .i_D_WStrb(ds[k]), .o_D_Ready(dr[k]),
      .o_D_Rsp_Valid(drv[k]), .o_D_Rsp_Data(drd[k]),
      .o_Mem_En(men[k]), .o_Mem_We(mwe[k]), .o_Mem_Addr(maddr[k]), .o_Mem_WData(mwd[k]),
      .i_Mem_RData(mrd[k])
    );
  end

  // Synchronous RAMs (16 words used), cleared by reset
  logic [31:0] ram[2][16];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int a = 0; a < 16; a++) ram[k][a] <= 32'd0;
        mrd[k] <= 32'd0;
      end else if (men[k]) begin
        for (int b = 0; b < 4; b++)
          if (mwe[k][b]) ram[k][maddr[k][3:0]][b*8 +: 8] <= mwd[k][b*8 +: 8];
        mrd[k] <= ram[k][maddr[k][3:0]];
      end
    end
  end

  // Reference model: each accepted transfer is a record; expected outputs are
  // the record accepted one cycle ago (RAM command) and two cycles ago (response).
  typedef struct packed {
    logic          v;
    logic          d;
    logic          wr;
    logic [AW-1:0] a;
    logic [31:0]   wd;
    logic [3:0]    s;
    logic [31:0]   rd;
  } xfer_t;

  xfer_t         s1[2];
  xfer_t         s2[2];
  logic [31:0]   gold[2][16];
  bit            last_d[2];
  int            wcnt[2];
  logic [AW-1:0] h_addr[2];
  logic [31:0]   h_wd[2];
  bit            mg_i[2];
  bit            mg_d[2];
  bit            last_dr[2];
  int            n_vec;
  int            n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs applied; checks the cycle,
  // advances the model across the next rising edge, returns at the next falling edge.
  task automatic cyc();
    #1;
    for (int k = 0; k < 2; k++) begin
      bit gi, gd;
      xfer_t t;
      gi = 1'b0;
      gd = 1'b0;
      if (!rst) begin
        if (iv[k] && dv[k]) begin
          if (k == 0) gd = !last_d[k];
          else        gd = (wcnt[k] < MW);
          gi = !gd;
        end else begin
          gi = iv[k];
          gd = dv[k];
        end
      end
      mg_i[k] = gi;
      mg_d[k] = gd;
      last_dr[k] = dr[k];

      chk($sformatf("m%0d_i_ready", k), 32'(ir[k]), 32'(gi));
      chk($sformatf("m%0d_d_ready", k), 32'(dr[k]), 32'(gd));
      chk($sformatf("m%0d_mem_en", k), 32'(men[k]), 32'(s1[k].v));
      chk($sformatf("m%0d_mem_we", k), 32'(mwe[k]), (s1[k].v && s1[k].wr) ? 32'(s1[k].s) : 32'd0);
      chk($sformatf("m%0d_mem_addr", k), 32'(maddr[k]), 32'(h_addr[k]));
      chk($sformatf("m%0d_mem_wdata", k), mwd[k], h_wd[k]);
      chk($sformatf("m%0d_i_rsp_valid", k), 32'(irv[k]), 32'(s2[k].v && !s2[k].d));
      chk($sformatf("m%0d_d_rsp_valid", k), 32'(drv[k]), 32'(s2[k].v && s2[k].d));
      if (s2[k].v && !s2[k].d) chk($sformatf("m%0d_i_rsp_data", k), ird[k], s2[k].rd);
      if (s2[k].v && s2[k].d)
        chk($sformatf("m%0d_d_rsp_data", k), drd[k], s2[k].wr ? 32'd0 : s2[k].rd);

      if (rst) begin
        s1[k] = '0;
        s2[k] = '0;
        last_d[k] = 1'b0;
        wcnt[k] = 0;
        h_addr[k] = '0;
        h_wd[k] = 32'd0;
        for (int a = 0; a < 16; a++) gold[k][a] = 32'd0;
      end else begin
        s2[k] = s1[k];
        t = '0;
        if (gi) begin
          t.v = 1'b1;
          t.a = ia[k];
        end
        if (gd) begin
          t.v = 1'b1;
          t.d = 1'b1;
          t.wr = dwr[k];
          t.a = da[k];
          t.wd = dwd[k];
          t.s = ds[k];
          h_wd[k] = dwd[k];
        end
        if (t.v) begin
          h_addr[k] = t.a;
          t.rd = gold[k][t.a[3:0]];
          if (t.wr)
            for (int b = 0; b < 4; b++)
              if (t.s[b]) gold[k][t.a[3:0]][b*8 +: 8] = t.wd[b*8 +: 8];
          last_d[k] = gd;
        end
        if (iv[k] && !gi) wcnt[k] = (wcnt[k] < MW) ? wcnt[k] + 1 : MW;
        else              wcnt[k] = 0;
        s1[k] = t;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0;
      dv[k] = 1'b0;
    end
  endtask

  task automatic set_d(input logic wr, input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] s);
    for (int k = 0; k < 2; k++) begin
      dv[k] = 1'b1; dwr[k] = wr; da[k] = a; dwd[k] = wd; ds[k] = s;
    end
  endtask

  task automatic set_i(input logic [AW-1:0] a);
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b1; ia[k] = a;
    end
  endtask

  // New random request per port unless the previous one is still waiting.
  task automatic rand_drive(input int p_i, input int p_d);
    for (int k = 0; k < 2; k++) begin
      if (!(iv[k] && !mg_i[k])) begin
        iv[k] = ($urandom_range(0, 99) < p_i);
        ia[k] = AW'($urandom_range(0, 15));
      end
      if (!(dv[k] && !mg_d[k])) begin
        dv[k]  = ($urandom_range(0, 99) < p_d);
        dwr[k] = 1'($urandom_range(0, 1));
        da[k]  = AW'($urandom_range(0, 15));
        dwd[k] = $urandom;
        ds[k]  = 4'($urandom_range(0, 15));
      end
    end
  endtask

  logic [9:0] pat0, pat1;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b1; ia[k] = '0; dv[k] = 1'b1; dwr[k] = 1'b0; da[k] = '0;
      dwd[k] = 32'd0; ds[k] = 4'd0;
      s1[k] = '0; s2[k] = '0; last_d[k] = 1'b0; wcnt[k] = 0;
      h_addr[k] = '0; h_wd[k] = 32'd0; mg_i[k] = 1'b0; mg_d[k] = 1'b0;
      for (int a = 0; a < 16; a++) gold[k][a] = 32'd0;
    end
    @(negedge clk);

    // Reset with both ports requesting: no Ready, all outputs 0
    cyc();
    cyc();
    rst = 1'b0;
    idle();
    cyc();

    // Preload RAM[5] through D
    set_d(1'b1, AW'(5), 32'hDEADBEEF, 4'hF);
    cyc();
    idle();
    cyc(); cyc(); cyc();

    // Single I read of address 5
    set_i(AW'(5));
    cyc();
    idle();
    cyc();
    #1;
    chk("i_read_rsp_valid", 32'(irv[0]), 32'd1);
    chk("i_read_rsp_data", ird[0], 32'hDEADBEEF);
    chk("i_read_no_d_rsp", 32'(drv[0]), 32'd0);
    cyc();

    // Byte write to address 3, then read it back
    set_d(1'b1, AW'(3), 32'h11223344, 4'b0101);
    cyc();
    idle();
    #1;
    chk("d_write_mem_we", 32'(mwe[0]), 32'h5);
    cyc();
    #1;
    chk("d_write_ack_valid", 32'(drv[1]), 32'd1);
    chk("d_write_ack_data", drd[1], 32'd0);
    cyc();
    set_d(1'b0, AW'(3), 32'd0, 4'd0);
    cyc();
    idle();
    cyc();
    #1;
    chk("d_read_back_m0", drd[0], 32'h00220044);
    chk("d_read_back_m1", drd[1], 32'h00220044);
    cyc();

    // Contention from reset: both ports always valid for 10 cycles
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mg_i[k] = 1'b0;
      mg_d[k] = 1'b0;
      iv[k] = 1'b0;
      dv[k] = 1'b0;
    end
    rand_drive(100, 100);
    pat0 = '0;
    pat1 = '0;
    for (int j = 0; j < 10; j++) begin
      cyc();
      pat0 = {pat0[8:0], last_dr[0]};
      pat1 = {pat1[8:0], last_dr[1]};
      rand_drive(100, 100);
    end
    chk("rr_grant_order", 32'(pat0), 32'h2AA);
    chk("prio_grant_order", 32'(pat1), 32'h3DE);

    // Reset while a D read is in flight
    idle();
    cyc(); cyc(); cyc();
    set_d(1'b0, AW'(5), 32'd0, 4'd0);
    cyc();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_i(AW'(1));
    set_d(1'b0, AW'(2), 32'd0, 4'd0);
    #1;
    chk("rst_drop_d_rsp", 32'(drv[0]), 32'd0);
    chk("rst_mem_addr", 32'(maddr[0]), 32'd0);
    chk("rst_tie_d_wins", 32'(dr[0]), 32'd1);
    chk("rst_tie_i_loses", 32'(ir[0]), 32'd0);
    cyc();
    idle();
    cyc(); cyc(); cyc();

    // Stalled I request at address 7 while D keeps winning (priority instance)
    set_d(1'b1, AW'(7), 32'hCAFEF00D, 4'hF);
    cyc();
    idle();
    cyc(); cyc();
    set_i(AW'(7));
    set_d(1'b0, AW'(1), 32'd0, 4'd0);
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("stall_i_ready", 32'(ir[1]), 32'd0);
      cyc();
      for (int k = 0; k < 2; k++) begin
        if (mg_d[k]) da[k] = da[k] + AW'(1);
        if (mg_i[k]) iv[k] = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++) dv[k] = 1'b0;
    #1;
    chk("stall_i_granted", 32'(ir[1]), 32'd1);
    cyc();
    idle();
    cyc();
    #1;
    chk("stall_rsp_valid", 32'(irv[1]), 32'd1);
    chk("stall_rsp_data", ird[1], 32'hCAFEF00D);
    cyc();

    // Random traffic
    for (int j = 0; j < 400; j++) begin
      rand_drive(60, 60);
      cyc();
    end
    idle();
    cyc(); cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
